// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal NIC: register map, default width and packet field layout.
package cardinal_nic_pkg;

  localparam int NIC_DATA_W = 64;

  localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

  // Packet fields use big-endian numbering: bit 0 is the MSB.
  localparam int PKT_VC_BIT      = 0;
  localparam int PKT_DIR_BIT     = 1;
  localparam int PKT_HOP_FIRST   = 8;
  localparam int PKT_HOP_LAST    = 15;
  localparam int PKT_SRC_FIRST   = 16;
  localparam int PKT_SRC_LAST    = 31;
  localparam int PKT_PAY_FIRST   = 32;
  localparam int PKT_PAY_LAST    = 63;

  function automatic logic nic_hit(input logic en, input logic wr, input logic [1:0] addr,
                                   input logic [1:0] sel, input logic want_wr);
    return en && (wr == want_wr) && (addr == sel);
  endfunction

endpackage

// File: rtl/nic_channel_buffer.sv
// Single-entry packet buffer with a full flag; load is honoured only while empty.
module nic_channel_buffer
  import cardinal_nic_pkg::*;
#(
  parameter int W = NIC_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         unload,
  input  logic [0:W-1] load_data,
  output logic         full,
  output logic [0:W-1] data
);

  logic         full_d, full_q;
  logic [0:W-1] data_d, data_q;

  // Next-state: capture when empty, release on unload.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load && !full_q) begin
      full_d = 1'b1;
      data_d = load_data;
    end else if (unload) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Buffer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal ring NIC: processor register port plus router inject/eject handshakes.
// Optional macro CARDINAL_NIC_POLARITY_EN gates injection on VC bit vs. ring polarity.
module cardinal_nic
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_W = NIC_DATA_W,
  parameter int VC_BIT = PKT_VC_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:1]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di
);

  logic              out_full_s, in_full_s;
  logic [0:DATA_W-1] out_data_s, in_data_s;
  logic              wr_out_s, rd_in_s, pol_ok_s;

  assign wr_out_s = nic_hit(nicEn, nicWrEn, addr, NIC_ADDR_OUT_BUF, 1'b1);
  assign rd_in_s  = nic_hit(nicEn, nicWrEn, addr, NIC_ADDR_IN_BUF, 1'b0) && in_full_s;

`ifdef CARDINAL_NIC_POLARITY_EN
  assign pol_ok_s = (out_data_s[VC_BIT] == net_polarity);
`else
  logic unused_polarity_s;
  assign unused_polarity_s = net_polarity;
  assign pol_ok_s = 1'b1;
`endif

  assign net_so = out_full_s && net_ro && pol_ok_s;
  assign net_do = out_data_s;
  assign net_ri = ~in_full_s;

  nic_channel_buffer #(.W(DATA_W)) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (wr_out_s),
    .unload    (net_so),
    .load_data (d_in),
    .full      (out_full_s),
    .data      (out_data_s)
  );

  // Capture only when empty, so a read-clear and a new arrival never collide.
  nic_channel_buffer #(.W(DATA_W)) u_in_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (net_si && net_ri),
    .unload    (rd_in_s),
    .load_data (net_di),
    .full      (in_full_s),
    .data      (in_data_s)
  );

  // Read mux; status flags land in the last (least significant) bit.
  always_comb begin
    d_out = '0;
    if (nicEn && !nicWrEn) begin
      case (addr)
        NIC_ADDR_IN_BUF:   d_out = in_data_s;
        NIC_ADDR_IN_STAT:  d_out[DATA_W-1] = in_full_s;
        NIC_ADDR_OUT_BUF:  d_out = out_data_s;
        NIC_ADDR_OUT_STAT: d_out[DATA_W-1] = out_full_s;
        default:           d_out = '0;
      endcase
    end else begin
      d_out = '0;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed self-checking bench for cardinal_nic (default width 64, VC bit 0).
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in, d_out, net_do, net_di;
  logic        nicEn, nicWrEn, net_so, net_ro, net_polarity, net_si, net_ri;

  int total = 0;
  int bad   = 0;

  cardinal_nic dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
    .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
    .net_ri(net_ri), .net_di(net_di)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; polarity flips every cycle just after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
    net_polarity = ~net_polarity;
  endtask

  task automatic rd(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    #1;
  endtask

  task automatic idle;
    nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00;
    #1;
  endtask

  function automatic logic pol_ok(input logic vc, input logic pol);
`ifdef CARDINAL_NIC_POLARITY_EN
    return vc == pol;
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    logic exp_full;
    logic exp_so;
    int   pulses;
    int   pulse_pol;
    logic seen;

    reset = 1'b1; addr = 2'b00; d_in = 64'h0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = 64'h0;
    #2;
    check("rst_so", {63'h0, net_so}, 64'h0);
    check("rst_ri", {63'h0, net_ri}, 64'h1);
    check("rst_do", net_do, 64'h0);
    check("rst_dout", d_out, 64'h0);
    tick; tick;
    reset = 1'b0;
    tick;

    rd(2'b01); check("idle_in_stat", d_out, 64'h0);
    rd(2'b11); check("idle_out_stat", d_out, 64'h0);
    nicWrEn = 1'b1; #1; check("dout_zero_on_write", d_out, 64'h0);
    idle;

    // Single outbound packet, router ready.
    net_ro = 1'b1;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h0000_0000_DEAD_BEEF;
    tick;
    idle;
    exp_full = 1'b1; pulses = 0; pulse_pol = -1;
    for (int i = 0; i < 6; i++) begin
      exp_so = exp_full && pol_ok(1'b0, net_polarity);
      check($sformatf("inj_so_c%0d", i), {63'h0, net_so}, {63'h0, exp_so});
      if (net_so) begin
        pulses++;
        pulse_pol = net_polarity;
        check("inj_do", net_do, 64'h0000_0000_DEAD_BEEF);
      end
      if (exp_so) exp_full = 1'b0;
      tick;
    end
    check("inj_pulses", pulses, 64'd1);
`ifdef CARDINAL_NIC_POLARITY_EN
    check("inj_pol", pulse_pol, 64'd0);
`endif
    rd(2'b11); check("inj_out_stat_after", d_out, 64'h0);
    idle;

    // Second write while full is dropped; also a write during the injection cycle.
    net_ro = 1'b0;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h1111_2222_3333_4444;
    tick;
    d_in = 64'h5555_6666_7777_8888;
    tick;
    rd(2'b10); check("drop_out_buf", d_out, 64'h1111_2222_3333_4444);
    rd(2'b11); check("drop_out_stat", d_out, 64'h1);
    net_ro = 1'b1;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h9999_AAAA_BBBB_CCCC;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      #1;
      if (net_so) seen = 1'b1;
      tick;
    end
    check("coll_inject_seen", {63'h0, seen}, 64'h1);
    net_ro = 1'b0;
    rd(2'b11); check("coll_out_stat", d_out, 64'h0);
    rd(2'b10); check("coll_out_buf", d_out, 64'h1111_2222_3333_4444);
    idle;

    // Inbound packet and read-to-clear.
    net_si = 1'b1; net_di = 64'h1234;
    tick;
    net_si = 1'b0; net_di = 64'h0;
    check("rx_ri_low", {63'h0, net_ri}, 64'h0);
    rd(2'b01); check("rx_in_stat", d_out, 64'h1);
    rd(2'b00); check("rx_in_buf", d_out, 64'h1234);
    tick;
    rd(2'b01); check("rx_in_stat_clr", d_out, 64'h0);
    check("rx_ri_high", {63'h0, net_ri}, 64'h1);
    idle;

    // Router holds net_si across a read: no overwrite, capture one cycle later.
    net_si = 1'b1; net_di = 64'hAAAA;
    tick;
    net_di = 64'h5555;
    tick;
    rd(2'b00); check("hold_in_buf_kept", d_out, 64'hAAAA);
    tick;
    rd(2'b01); check("hold_in_stat_clr", d_out, 64'h0);
    check("hold_ri", {63'h0, net_ri}, 64'h1);
    idle;
    tick;
    net_si = 1'b0;
    rd(2'b01); check("hold_in_stat_cap", d_out, 64'h1);
    rd(2'b00); check("hold_in_buf_new", d_out, 64'h5555);
    tick;
    rd(2'b01); check("hold_in_stat_end", d_out, 64'h0);
    idle;

    // Asynchronous reset with both buffers full.
    net_ro = 1'b0;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'hFEED_0000_0000_0001;
    net_si = 1'b1; net_di = 64'h77;
    tick;
    net_si = 1'b0;
    rd(2'b11); check("full_out_stat", d_out, 64'h1);
    rd(2'b01); check("full_in_stat", d_out, 64'h1);
    reset = 1'b1;
    #1;
    check("arst_ri", {63'h0, net_ri}, 64'h1);
    check("arst_do", net_do, 64'h0);
    rd(2'b01); check("arst_in_stat", d_out, 64'h0);
    rd(2'b11); check("arst_out_stat", d_out, 64'h0);
    rd(2'b00); check("arst_in_buf", d_out, 64'h0);
    idle;
    tick;
    reset = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
